bus_arbiter_rr: RTL



---
 rtl/bus_arb_pkg.sv | 43 ++++
 rtl/bus_arbiter_rr_if.sv | 39 +++
 rtl/rr_pick.sv | 30 +++
 rtl/bus_arbiter_rr.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority bus arbiter.
//   arb_state_t    : grant/ownership/release state encoding
//   RR_MODE_*      : arbitration policy encodings for the RR_MODE parameter
//   pick_t         : result of a rotate-priority search (found flag + index)
//   next_rr_winner : first set request bit scanning last+1, last+2, ... mod n
package bus_arb_pkg;

  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_IDX_W = 4;

  localparam int unsigned RR_MODE_FIXED = 0;
  localparam int unsigned RR_MODE_RR    = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    OWNED   = 2'd2,
    TURN    = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // Rotating priority search; fixed priority is the special case last = n-1.
  function automatic pick_t next_rr_winner(input logic [MAX_REQ-1:0]   req,
                                           input logic [MAX_IDX_W-1:0] last,
                                           input int unsigned          n);
    pick_t res;
    res = '0;
    for (int unsigned off = 1; off <= MAX_REQ; off++) begin
      logic [MAX_IDX_W-1:0] idx;
      idx = MAX_IDX_W'((32'(last) + off) % n);
      if ((off <= n) && !res.found && req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Arbiter handshake bundle between the requesters and the arbiter.
//   in_reqcyc       : per-requester level request (bit i = requester i)
//   in_bus_busy     : OR of all requesters' busy; high while owner has a transfer in flight
//   out_grant       : one-hot grant
//   out_grant_valid : any grant asserted
//   out_grant_idx   : index of current grantee, 0 when none
//   out_timeout     : one-cycle pulse when a grant is revoked
// master = requester side, slave = arbiter side.
interface bus_arbiter_rr_if #(
  parameter int unsigned NUM_REQ = 6,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0] in_reqcyc;
  logic               in_bus_busy;
  logic [NUM_REQ-1:0] out_grant;
  logic               out_grant_valid;
  logic [IDX_W-1:0]   out_grant_idx;
  logic               out_timeout;

  modport master (
    output in_reqcyc,
    output in_bus_busy,
    input  out_grant,
    input  out_grant_valid,
    input  out_grant_idx,
    input  out_timeout
  );

  modport slave (
    input  in_reqcyc,
    input  in_bus_busy,
    output out_grant,
    output out_grant_valid,
    output out_grant_idx,
    output out_timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder.
//   req_i     : request vector
//   last_i    : index of the most recent owner; search starts at last_i+1
//   found_c_o : some request bit is set
//   idx_c_o   : winning index (0 when nothing found)
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 6,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               found_c_o,
  output logic [IDX_W-1:0]   idx_c_o
);

  pick_t pick_c;
  logic  unused_idx_hi_c;

  always_comb begin
    pick_c    = next_rr_winner(MAX_REQ'(req_i), MAX_IDX_W'(last_i), NUM_REQ);
    found_c_o = pick_c.found;
    idx_c_o   = IDX_W'(pick_c.idx);
  end

  // Upper index bits are always zero for NUM_REQ below the package maximum.
  assign unused_idx_hi_c = ^pick_c.idx;

endmodule

// File: rtl/bus_arbiter_rr.sv
// Shared system-bus arbiter for NUM_REQ requesters.
// Policy is round-robin (RR_MODE=1) or fixed lowest-index priority (RR_MODE=0).
// A grant walks IDLE -> GRANTED -> OWNED -> TURN -> IDLE; TURN is a dead
// cycle for bus turnaround. All outputs are registered.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : bus_arbiter_rr_if.slave (requests, busy, grant, grant index, timeout)
// Optional feature macro: BUS_ARBITER_TIMEOUT_EN
//   defined   : a grantee that does not raise busy within GRANT_TIMEOUT cycles
//               loses the grant, out_timeout pulses, the RR pointer skips it.
//   undefined : no counter, out_timeout tied 0, GRANTED waits indefinitely.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 6,
  parameter int unsigned RR_MODE       = 1,
  parameter int unsigned GRANT_TIMEOUT = 15,
  parameter int unsigned IDX_W         = $clog2(NUM_REQ)
) (
  input logic           clk,
  input logic           reset,
  bus_arbiter_rr_if.slave bus
);

  // Elaboration-time parameter sanity.
  if ((NUM_REQ < 2) || (NUM_REQ > MAX_REQ) || (GRANT_TIMEOUT == 0) ||
      ((RR_MODE != RR_MODE_RR) && (RR_MODE != RR_MODE_FIXED))) begin : g_cfg_err
    $error("bus_arbiter_rr: unsupported parameter combination");
  end

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               valid_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   last_q;

  logic               pick_found_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic [IDX_W-1:0]   pick_last_c;

  // Fixed priority is a rotation that always starts just past the top index.
  assign pick_last_c = (RR_MODE == RR_MODE_RR) ? last_q : IDX_W'(NUM_REQ - 1);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i     (bus.in_reqcyc),
    .last_i    (pick_last_c),
    .found_c_o (pick_found_c),
    .idx_c_o   (pick_idx_c)
  );

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(GRANT_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_q;
  logic             expired_c;

  // Cycles spent in GRANTED without busy; cleared in every other state.
  always_comb begin
    cnt_d = '0;
    if (state_q == GRANTED) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign expired_c = (cnt_q == CNT_W'(GRANT_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.out_timeout = timeout_q;
`else
  assign bus.out_timeout = 1'b0;
`endif

  // Grant / ownership / release state machine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
`ifdef BUS_ARBITER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // A stale busy from a previous owner blocks any new grant.
          if (!bus.in_bus_busy && pick_found_c) begin
            grant_q <= NUM_REQ'(1) << pick_idx_c;
            valid_q <= 1'b1;
            idx_q   <= pick_idx_c;
            state_q <= GRANTED;
          end
        end
        GRANTED: begin
          // Busy beats a simultaneous request drop.
          if (bus.in_bus_busy) begin
            last_q  <= idx_q;
            state_q <= OWNED;
          end else if (!bus.in_reqcyc[idx_q]) begin
            // Abandoned grant: pointer deliberately left alone.
            grant_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            state_q <= TURN;
          end
`ifdef BUS_ARBITER_TIMEOUT_EN
          else if (expired_c) begin
            grant_q   <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            last_q    <= idx_q;
            timeout_q <= 1'b1;
            state_q   <= TURN;
          end
`endif
        end
        OWNED: begin
          if (!bus.in_bus_busy) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            state_q <= TURN;
          end
        end
        TURN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_grant       = grant_q;
  assign bus.out_grant_valid = valid_q;
  assign bus.out_grant_idx   = idx_q;

endmodule
